guess_ctrl: RTL and testbench



---
 rtl/guess_pkg.sv | 31 +++
 rtl/lfsr8.sv | 21 ++
 rtl/guess_ctrl.sv | 151 +++++++++++++++
 tb/tb_guess_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing game controller.
package guess_pkg;

    // Game controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Display word layout: [19:16] blank mask (1 = blank), [15:0] hex digits 3..0
    localparam int         BLANK_MSB = 19;
    localparam int         BLANK_LSB = 16;
    localparam logic [3:0] BLANK_ALL = 4'hF;
    localparam logic [3:0] BLANK_D2  = 4'b0100;

    // btn_pulse bit indices
    localparam int BTN_GO    = 0;
    localparam int BTN_ABORT = 1;

    // Display word shown while idle: every digit blanked
    localparam logic [19:0] DATA_IDLE = {BLANK_ALL, 16'h0000};

    // Game display: tries on digit 3, digit 2 blank, an 8-bit value on digits 1..0
    function automatic logic [19:0] show_word(input logic [3:0] tries, input logic [7:0] value);
        return {BLANK_D2, tries, 4'h0, value};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length, never 0).
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    localparam logic [7:0] TAPS = 8'hB8;

    // Load the seed in reset, otherwise shift right and fold the feedback into the taps
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[7:1]} ^ (q[0] ? TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/guess_ctrl.sv
// Number-guessing game controller: draws a secret from the LFSR, grades guesses
// entered on sw and drives the display word and status LEDs (all registered).
module guess_ctrl
    import guess_pkg::*;
#(
    parameter int         MAX_TRIES = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic [3:0]  btn_pulse,
    output logic [19:0] data,
    output logic [7:0]  led
);

    localparam int         BLINK_W    = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [3:0] MAX_T4     = 4'(MAX_TRIES);

    state_t               state_r;
    logic [7:0]           secret_r;
    logic [7:0]           guess_r;
    logic [3:0]           tries_r;
    logic [1:0]           hint_r;       // [1] = too high, [0] = too low
    logic [BLINK_W-1:0]   blink_cnt_r;
    logic [19:0]          data_r;
    logic [7:0]           led_r;
    logic [7:0]           lfsr_s;

    logic                 go_s;
    logic                 abort_s;
    logic [3:0]           tries_inc_s;
    logic                 too_high_s;
    logic                 too_low_s;
    logic                 blink_wrap_s;
    logic                 btn_unused_s;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    // Decode buttons and precompute grading / blink helpers
    always_comb begin
        go_s         = btn_pulse[BTN_GO];
        abort_s      = btn_pulse[BTN_ABORT];
        btn_unused_s = ^btn_pulse[3:2];
        tries_inc_s  = tries_r + 4'd1;
        too_high_s   = (guess_r > secret_r);
        too_low_s    = (guess_r < secret_r);
        blink_wrap_s = (blink_cnt_r == BLINK_LAST);
    end

    // Game FSM; output registers are loaded with the values of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            secret_r    <= 8'h00;
            guess_r     <= 8'h00;
            tries_r     <= 4'h0;
            hint_r      <= 2'b00;
            blink_cnt_r <= '0;
            data_r      <= DATA_IDLE;
            led_r       <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s && !abort_s) begin
                        state_r  <= ST_PLAY;
                        secret_r <= lfsr_s;
                        tries_r  <= 4'h0;
                        hint_r   <= 2'b00;
                        data_r   <= show_word(4'h0, sw);
                        led_r    <= 8'h00;
                    end else begin
                        data_r <= DATA_IDLE;
                        led_r  <= 8'h00;
                    end
                end
                ST_PLAY: begin
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                        data_r  <= DATA_IDLE;
                        led_r   <= 8'h00;
                    end else begin
                        if (go_s) begin
                            state_r <= ST_CHECK;
                            guess_r <= sw;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                        data_r <= show_word(tries_r, sw);
                        led_r  <= {hint_r, 2'b00, tries_r};
                    end
                end
                ST_CHECK: begin
                    // Buttons are deliberately ignored for this single grading cycle
                    tries_r <= tries_inc_s;
                    hint_r  <= {too_high_s, too_low_s};
                    if (guess_r == secret_r) begin
                        state_r     <= ST_WIN;
                        blink_cnt_r <= '0;
                        data_r      <= show_word(tries_inc_s, secret_r);
                        led_r       <= 8'hFF;
                    end else if (tries_inc_s == MAX_T4) begin
                        state_r <= ST_LOSE;
                        data_r  <= show_word(tries_inc_s, secret_r);
                        led_r   <= 8'h01;
                    end else begin
                        state_r <= ST_PLAY;
                        data_r  <= show_word(tries_inc_s, sw);
                        led_r   <= {too_high_s, too_low_s, 2'b00, tries_inc_s};
                    end
                end
                ST_WIN: begin
                    if (abort_s || go_s) begin
                        state_r <= ST_IDLE;
                        data_r  <= DATA_IDLE;
                        led_r   <= 8'h00;
                    end else if (blink_wrap_s) begin
                        blink_cnt_r <= '0;
                        led_r       <= ~led_r;
                    end else begin
                        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
                    end
                end
                ST_LOSE: begin
                    if (abort_s || go_s) begin
                        state_r <= ST_IDLE;
                        data_r  <= DATA_IDLE;
                        led_r   <= 8'h00;
                    end else begin
                        state_r <= ST_LOSE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    data_r  <= DATA_IDLE;
                    led_r   <= 8'h00;
                end
            endcase
        end
    end

    assign data = data_r;
    assign led  = led_r;

endmodule

// File: tb/tb_guess_ctrl.sv
// Self-checking bench for guess_ctrl: directed game scenarios followed by
// randomized play, all compared against a behavioural game model.
module tb_guess_ctrl;

    localparam int         MAX_T  = 3;
    localparam int         BDIV   = 4;
    localparam logic [7:0] SEED   = 8'hA5;

    localparam int M_IDLE = 0, M_PLAY = 1, M_CHECK = 2, M_WIN = 3, M_LOSE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic [3:0]  btn_pulse;
    logic [19:0] data;
    logic [7:0]  led;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural game model
    int         m_state;
    logic [7:0] m_secret, m_guess, m_lfsr, m_shown_sw;
    int         m_tries;
    bit         m_hi, m_lo;
    int         m_win_cycles;

    guess_ctrl #(
        .MAX_TRIES (MAX_T),
        .LFSR_SEED (SEED),
        .BLINK_DIV (BDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_pulse (btn_pulse),
        .data      (data),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        // multiply by x^-1 modulo x^8+x^6+x^5+x^4+1
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic logic [19:0] exp_data();
        case (m_state)
            M_IDLE:  return 20'hF0000;
            M_PLAY:  return {4'b0100, 4'(m_tries), 4'h0, m_shown_sw};
            default: return {4'b0100, 4'(m_tries), 4'h0, m_secret};
        endcase
    endfunction

    function automatic logic [7:0] exp_led();
        case (m_state)
            M_IDLE:  return 8'h00;
            M_PLAY:  return {m_hi, m_lo, 2'b00, 4'(m_tries)};
            M_WIN:   return (((m_win_cycles / BDIV) % 2) == 0) ? 8'hFF : 8'h00;
            default: return 8'h01;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] s, input logic [3:0] b);
        bit go, ab;
        go = b[0];
        ab = b[1];
        if (r) begin
            m_state = M_IDLE; m_secret = 8'h00; m_guess = 8'h00; m_tries = 0;
            m_hi = 1'b0; m_lo = 1'b0; m_win_cycles = 0; m_lfsr = SEED;
        end else begin
            case (m_state)
                M_IDLE: if (go && !ab) begin
                    m_secret = m_lfsr; m_tries = 0; m_hi = 1'b0; m_lo = 1'b0; m_state = M_PLAY;
                end
                M_PLAY: if (ab) m_state = M_IDLE;
                        else if (go) begin m_guess = s; m_state = M_CHECK; end
                M_CHECK: begin
                    m_tries++;
                    if (m_guess == m_secret) begin
                        m_state = M_WIN; m_win_cycles = 0;
                    end else begin
                        m_hi = (m_guess > m_secret);
                        m_lo = (m_guess < m_secret);
                        m_state = (m_tries == MAX_T) ? M_LOSE : M_PLAY;
                    end
                end
                M_WIN:  if (ab || go) m_state = M_IDLE; else m_win_cycles++;
                default: if (ab || go) m_state = M_IDLE;
            endcase
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_shown_sw = s;
    endtask

    // One clock: drive inputs, advance DUT and model, compare outputs after the edge
    task automatic step(input logic r, input logic [7:0] s, input logic [3:0] b);
        rst = r; sw = s; btn_pulse = b;
        @(posedge clk);
        model_edge(r, s, b);
        #1;
        if (m_state != M_CHECK) begin
            chk("data", 32'(data), 32'(exp_data()));
            chk("led", 32'(led), 32'(exp_led()));
        end
    endtask

    initial begin
        logic [7:0] g;
        logic       r;
        logic [3:0] b;
        rst = 1'b1; sw = 8'h00; btn_pulse = 4'h0;
        m_state = M_IDLE; m_tries = 0; m_lfsr = SEED; m_secret = 8'h00;
        m_guess = 8'h00; m_hi = 1'b0; m_lo = 1'b0; m_win_cycles = 0; m_shown_sw = 8'h00;

        // Reset for three cycles
        repeat (3) step(1'b1, 8'h00, 4'h0);
        chk("reset_data", 32'(data), 32'h000F0000);
        chk("reset_led", 32'(led), 32'h0);

        // Start right after reset: secret is the seed; win in one guess
        step(1'b0, 8'hA5, 4'b0001);
        chk("start_play", 32'(data), 32'h000400A5);
        step(1'b0, 8'hA5, 4'b0001);
        step(1'b0, 8'hA5, 4'b0000);
        chk("win_data", 32'(data), 32'h000410A5);
        chk("win_led_on", 32'(led), 32'hFF);
        repeat (4) step(1'b0, 8'h00, 4'b0000);
        chk("win_led_off", 32'(led), 32'h00);
        step(1'b0, 8'h00, 4'b0001);
        chk("win_to_idle", 32'(data), 32'h000F0000);

        // Hints and lose with secret A5
        step(1'b1, 8'h00, 4'h0);
        step(1'b0, 8'hB0, 4'b0001);
        step(1'b0, 8'hB0, 4'b0001);
        step(1'b0, 8'hB0, 4'b0000);
        chk("hint_high", 32'(led), 32'h81);
        step(1'b0, 8'h00, 4'b0001);
        step(1'b0, 8'h00, 4'b0000);
        chk("hint_low", 32'(led), 32'h42);
        chk("hint_digits", 32'(data[19:12]), 32'h42);
        step(1'b0, 8'h10, 4'b0001);
        step(1'b0, 8'h10, 4'b0000);
        chk("lose_led", 32'(led), 32'h01);
        chk("lose_data", 32'(data), 32'h000430A5);
        step(1'b0, 8'h00, 4'b0001);
        chk("lose_to_idle", 32'(data), 32'h000F0000);

        // Simultaneous start/abort in PLAY, then abort during CHECK
        step(1'b0, 8'h00, 4'b0001);
        step(1'b0, 8'h00, 4'b0011);
        chk("abort_idle", 32'(data), 32'h000F0000);
        step(1'b0, 8'h00, 4'b0001);
        chk("restart_tries", 32'(led[3:0]), 32'h0);
        g = m_secret ^ 8'h01;
        step(1'b0, g, 4'b0001);
        step(1'b0, g, 4'b0010);
        chk("check_abort_ignored", 32'(led[3:0]), 32'h1);

        // Reach WIN, then reset mid-game; LFSR must restart at the seed
        g = m_secret;
        step(1'b0, g, 4'b0001);
        step(1'b0, g, 4'b0000);
        chk("win_again", 32'(led), 32'hFF);
        step(1'b1, 8'h00, 4'b0000);
        chk("midgame_reset_led", 32'(led), 32'h00);
        chk("midgame_reset_data", 32'(data), 32'h000F0000);
        step(1'b0, 8'hA5, 4'b0001);
        step(1'b0, 8'hA5, 4'b0001);
        step(1'b0, 8'hA5, 4'b0000);
        chk("reseed_win", 32'(data), 32'h000410A5);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            b = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 3) == 0)};
            if (m_state == M_PLAY && $urandom_range(0, 3) == 0) g = m_secret;
            else if ($urandom_range(0, 7) == 0) g = 8'h00;
            else g = 8'($urandom);
            step(r, g, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
